// File: rtl/control_unit_if.sv
// Control bus between the YASAC control unit and data_unit.
// master = control unit (drives strobes), slave = data_unit side.
interface control_unit_if;
    logic [4:0] opcode;
    logic [2:0] s;
    logic [7:0] status;
    logic [1:0] op;
    logic       ipc;
    logic       clpc;
    logic       wpc;
    logic       wir;
    logic       wreg;
    logic       inm;
    logic       wmem;
    logic       rmem;
    logic       wmar;
    logic       wsreg;
    logic       halted;

    modport master (
        input  opcode, s, status,
        output op, ipc, clpc, wpc, wir, wreg, inm, wmem, rmem, wmar, wsreg, halted
    );
    modport slave (
        output opcode, s, status,
        input  op, ipc, clpc, wpc, wir, wreg, inm, wmem, rmem, wmar, wsreg, halted
    );
endinterface

// File: rtl/control_unit.sv
// YASAC multicycle control unit: RESET -> FETCH -> EXEC [-> MEM] -> FETCH.
// Optional CU_ILLEGAL_HALT_EN: illegal opcodes halt instead of acting as NOP.
module control_unit #(
    parameter logic [1:0] OP_PASS_A = 2'b10,
    parameter logic [1:0] OP_PASS_B = 2'b11
) (
    input  logic          clk,
    input  logic          reset,
    control_unit_if.master cu
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [4:0] OPC_LD = 5'b01100;
    localparam logic [4:0] OPC_ST = 5'b01101;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cu.op     = 2'b00;
        cu.ipc    = 1'b0;
        cu.clpc   = 1'b0;
        cu.wpc    = 1'b0;
        cu.wir    = 1'b0;
        cu.wreg   = 1'b0;
        cu.inm    = 1'b0;
        cu.wmem   = 1'b0;
        cu.rmem   = 1'b0;
        cu.wmar   = 1'b0;
        cu.wsreg  = 1'b0;
        cu.halted = 1'b0;

        case (state_q)
            S_RESET: begin
                cu.clpc = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                cu.wir  = 1'b1;
                cu.ipc  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                casez (cu.opcode)
                    5'b00000: ;
                    5'b00001: state_d = S_HALT;
                    5'b001??: begin
                        cu.op    = cu.opcode[1:0];
                        cu.wreg  = 1'b1;
                        cu.wsreg = 1'b1;
                    end
                    5'b010??: begin
                        cu.op    = cu.opcode[1:0];
                        cu.inm   = 1'b1;
                        cu.wreg  = 1'b1;
                        cu.wsreg = 1'b1;
                    end
                    OPC_LD, OPC_ST: begin
                        cu.op   = OP_PASS_B;
                        cu.inm  = 1'b1;
                        cu.wmar = 1'b1;
                        state_d = S_MEM;
                    end
                    5'b01110: begin
                        cu.op  = OP_PASS_B;
                        cu.inm = 1'b1;
                        cu.wpc = 1'b1;
                    end
                    // Branches cost the same two cycles taken or not.
                    5'b01111: begin
                        if (cu.status[cu.s]) begin
                            cu.op  = OP_PASS_B;
                            cu.inm = 1'b1;
                            cu.wpc = 1'b1;
                        end
                    end
                    5'b10000: begin
                        if (!cu.status[cu.s]) begin
                            cu.op  = OP_PASS_B;
                            cu.inm = 1'b1;
                            cu.wpc = 1'b1;
                        end
                    end
                    default: begin
`ifdef CU_ILLEGAL_HALT_EN
                        state_d = S_HALT;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            // IR is not written in EXEC, so opcode still names the LD/ST here.
            S_MEM: begin
                state_d = S_FETCH;
                if (cu.opcode == OPC_LD) begin
                    cu.rmem = 1'b1;
                    cu.wreg = 1'b1;
                end else if (cu.opcode == OPC_ST) begin
                    cu.op   = OP_PASS_A;
                    cu.wmem = 1'b1;
                end
            end
            S_HALT: begin
                cu.halted = 1'b1;
                state_d   = S_HALT;
            end
            default: state_d = S_RESET;
        endcase
    end

endmodule
